multicycle_control: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 46 ++++
 rtl/mc_ctrl_decode.sv | 29 ++
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// MC_CTRL_ROT_EN (see mc_ctrl_decode) enables the rotate opcodes.
package mc_ctrl_pkg;

    localparam int unsigned OPC_W    = 6;
    localparam int unsigned ALUSEL_W = 5;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_ALUI    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_JR      = 3'd4,
        CLS_JAL     = 3'd5,
        CLS_BRANCH  = 3'd6,
        CLS_ILLEGAL = 3'd7
    } ins_class_e;

    localparam logic [OPC_W-1:0] OPC_ANDR = 6'b100000;
    localparam logic [OPC_W-1:0] OPC_NORR = 6'b100110;
    localparam logic [OPC_W-1:0] OPC_NOTR = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_ROLV = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_RORV = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_NORI = 6'b001110;
    localparam logic [OPC_W-1:0] OPC_LW   = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW   = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_JR   = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_JAL  = 6'b000011;
    localparam logic [OPC_W-1:0] OPC_BLEU = 6'b010000;

    localparam logic [PCSRC_W-1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [PCSRC_W-1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [PCSRC_W-1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [PCSRC_W-1:0] PC_SRC_REG    = 2'd3;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode-to-class decode.
// MC_CTRL_ROT_EN: when defined, rolv/rorv decode as register ALU ops; otherwise illegal.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic [2:0]       ins_class_o
);

    always_comb begin
        ins_class_o = CLS_ILLEGAL;
        case (opcode_i)
            OPC_ANDR, OPC_NORR, OPC_NOTR: ins_class_o = CLS_ALU;
`ifdef MC_CTRL_ROT_EN
            OPC_ROLV, OPC_RORV:           ins_class_o = CLS_ALU;
`else
            OPC_ROLV, OPC_RORV:           ins_class_o = CLS_ILLEGAL;
`endif
            OPC_NORI:                     ins_class_o = CLS_ALUI;
            OPC_LW:                       ins_class_o = CLS_LOAD;
            OPC_SW:                       ins_class_o = CLS_STORE;
            OPC_JR:                       ins_class_o = CLS_JR;
            OPC_JAL:                      ins_class_o = CLS_JAL;
            OPC_BLEU:                     ins_class_o = CLS_BRANCH;
            default:                      ins_class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake, traps and retire counter.
// Build option MC_CTRL_ROT_EN is resolved in mc_ctrl_decode.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned INS_W = 32,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INS_W-1:0]     ins,
    input  logic                 mem_ready,
    input  logic                 branch_cond,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ir_load,
    output logic                 pc_write,
    output logic [PCSRC_W-1:0]   pc_src,
    output logic                 reg_we,
    output logic                 reg_dst,
    output logic                 alu_src,
    output logic                 mem_to_reg,
    output logic                 branch_en,
    output logic [ALUSEL_W-1:0]  alu_sel,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     retired
);

    // Trap fires on the edge that ends the (2^TMO_W-1)th wait cycle.
    localparam logic [TMO_W-1:0] WAIT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic              retire;
    logic              mem_wait;
    logic [2:0]        cls_raw;
    ins_class_e        cls;
    logic              ins_unused;

    assign ins_unused = ^ins[INS_W-OPC_W-1:0];

    mc_ctrl_decode u_decode (
        .opcode_i    (ins[INS_W-1 -: OPC_W]),
        .ins_class_o (cls_raw)
    );

    assign cls = ins_class_e'(cls_raw);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state and Moore outputs; FETCH strobes are gated so reset holds them low.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        retired_d  = retired_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        retire     = 1'b0;
        mem_wait   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        branch_en  = 1'b0;
        alu_sel    = '0;

        case (state_q)
            ST_FETCH: begin
                mem_req = reset_n;
                if (mem_ready) begin
                    ir_load  = reset_n;
                    pc_write = reset_n;
                    state_d  = ST_DECODE;
                end else begin
                    mem_wait = 1'b1;
                end
            end
            ST_DECODE: begin
                if (cls == CLS_ILLEGAL) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_sel = ins[INS_W-1 -: ALUSEL_W];
                case (cls)
                    CLS_ALU: begin
                        reg_dst = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_ALUI: begin
                        alu_src = 1'b1;
                        reg_dst = 1'b1;
                        state_d = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    CLS_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_REG;
                        state_d  = ST_FETCH;
                        retire   = 1'b1;
                    end
                    CLS_JAL: state_d = ST_WB;
                    CLS_BRANCH: begin
                        branch_en = 1'b1;
                        pc_write  = branch_cond;
                        pc_src    = PC_SRC_BRANCH;
                        state_d   = ST_FETCH;
                        retire    = 1'b1;
                    end
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else begin
                    mem_wait = 1'b1;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (cls == CLS_LOAD);
                if (cls == CLS_JAL) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                end
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_TRAP;
        endcase

        if (mem_wait) begin
            if (wait_q == WAIT_LAST) begin
                state_d   = ST_TRAP;
                bus_err_d = 1'b1;
            end
            wait_d = wait_q + 1'b1;
        end

        if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
            wait_d = '0;
        end

        if (retire) begin
            retired_d = retired_q + 1'b1;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus trap/timeout/wrap sequences.
module tb_multicycle_control;

    localparam int unsigned INS_W = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO_W = 8;

    // Expected-output word layout: state(3) req we irl pcw pcs(2) rwe rdst asrc m2r ben asel(5)
    localparam logic [18:0] F_GO    = 19'b000_1_0_1_1_00_0_0_0_0_0_00000;
    localparam logic [18:0] F_WAIT  = 19'b000_1_0_0_0_00_0_0_0_0_0_00000;
    localparam logic [18:0] DEC     = 19'b001_0_0_0_0_00_0_0_0_0_0_00000;
    localparam logic [18:0] WB_REG  = 19'b100_0_0_0_0_00_1_0_0_0_0_00000;
    localparam logic [18:0] TRAP_O  = 19'b101_0_0_0_0_00_0_0_0_0_0_00000;
    localparam logic [18:0] RST_O   = 19'b000_0_0_0_0_00_0_0_0_0_0_00000;
    localparam logic [18:0] LW_E    = 19'b010_0_0_0_0_00_0_0_1_0_0_10001;
    localparam logic [18:0] LW_M    = 19'b011_1_0_0_0_00_0_0_0_0_0_00000;
    localparam logic [18:0] LW_W    = 19'b100_0_0_0_0_00_1_0_0_1_0_00000;
    localparam logic [18:0] SW_E    = 19'b010_0_0_0_0_00_0_0_1_0_0_10101;
    localparam logic [18:0] SW_M    = 19'b011_1_1_0_0_00_0_0_0_0_0_00000;
    localparam logic [18:0] NORI_E  = 19'b010_0_0_0_0_00_0_1_1_0_0_00111;
    localparam logic [18:0] ANDR_E  = 19'b010_0_0_0_0_00_0_1_0_0_0_10000;
    localparam logic [18:0] JR_E    = 19'b010_0_0_0_1_11_0_0_0_0_0_00100;
    localparam logic [18:0] JAL_E   = 19'b010_0_0_0_0_00_0_0_0_0_0_00001;
    localparam logic [18:0] JAL_W   = 19'b100_0_0_0_1_10_1_0_0_0_0_00000;
    localparam logic [18:0] BLEU1_E = 19'b010_0_0_0_1_01_0_0_0_0_1_01000;
    localparam logic [18:0] BLEU0_E = 19'b010_0_0_0_0_01_0_0_0_0_1_01000;
    localparam logic [18:0] NOTR_E  = 19'b010_0_0_0_0_00_0_1_0_0_0_00010;
    localparam logic [18:0] NORR_E  = 19'b010_0_0_0_0_00_0_1_0_0_0_10011;
    localparam logic [18:0] ROLV_E  = 19'b010_0_0_0_0_00_0_1_0_0_0_00000;

    localparam logic [31:0] I_LW   = 32'h8C00_0000;
    localparam logic [31:0] I_SW   = 32'hAC00_0000;
    localparam logic [31:0] I_NORI = 32'h3800_0000;
    localparam logic [31:0] I_ANDR = 32'h8000_0000;
    localparam logic [31:0] I_JR   = 32'h2000_0000;
    localparam logic [31:0] I_JAL  = 32'h0C00_0000;
    localparam logic [31:0] I_BLEU = 32'h4000_0000;
    localparam logic [31:0] I_NOTR = 32'h1000_0000;
    localparam logic [31:0] I_NORR = 32'h9800_0000;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;
    localparam logic [31:0] I_ROLV = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [INS_W-1:0]  ins;
    logic              mem_ready;
    logic              branch_cond;
    logic              mem_req, mem_we, ir_load, pc_write;
    logic [1:0]        pc_src;
    logic              reg_we, reg_dst, alu_src, mem_to_reg, branch_en;
    logic [4:0]        alu_sel;
    logic              illegal, bus_err;
    logic [2:0]        state;
    logic [CNT_W-1:0]  retired;
    logic [18:0]       act_o;

    typedef struct {
        logic [31:0] ins;
        logic        rdy;
        logic        bc;
        logic [18:0] exp_o;
        logic [3:0]  exp_ret;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .INS_W (INS_W),
        .CNT_W (CNT_W),
        .TMO_W (TMO_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ins         (ins),
        .mem_ready   (mem_ready),
        .branch_cond (branch_cond),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .branch_en   (branch_en),
        .alu_sel     (alu_sel),
        .illegal     (illegal),
        .bus_err     (bus_err),
        .state       (state),
        .retired     (retired)
    );

    assign act_o = {state, mem_req, mem_we, ir_load, pc_write, pc_src,
                    reg_we, reg_dst, alu_src, mem_to_reg, branch_en, alu_sel};

    function automatic vec_t mk(input logic [31:0] i, input logic r, input logic b,
                                input logic [18:0] o, input logic [3:0] rt);
        vec_t v;
        v.ins = i; v.rdy = r; v.bc = b; v.exp_o = o; v.exp_ret = rt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset two cycles, then releases it just after a rising edge.
    task automatic do_reset();
        reset_n = 1'b0; mem_ready = 1'b0; branch_cond = 1'b0; ins = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // Program run with hand-derived per-cycle outputs; one FETCH and one MEM stall included.
        vecs.push_back(mk(I_LW,   1'b0, 1'b0, F_WAIT,  4'd0));
        vecs.push_back(mk(I_LW,   1'b1, 1'b0, F_GO,    4'd0));
        vecs.push_back(mk(I_LW,   1'b1, 1'b0, DEC,     4'd0));
        vecs.push_back(mk(I_LW,   1'b1, 1'b0, LW_E,    4'd0));
        vecs.push_back(mk(I_LW,   1'b1, 1'b0, LW_M,    4'd0));
        vecs.push_back(mk(I_LW,   1'b1, 1'b0, LW_W,    4'd0));
        vecs.push_back(mk(I_SW,   1'b1, 1'b0, F_GO,    4'd1));
        vecs.push_back(mk(I_SW,   1'b1, 1'b0, DEC,     4'd1));
        vecs.push_back(mk(I_SW,   1'b1, 1'b0, SW_E,    4'd1));
        vecs.push_back(mk(I_SW,   1'b0, 1'b0, SW_M,    4'd1));
        vecs.push_back(mk(I_SW,   1'b1, 1'b0, SW_M,    4'd1));
        vecs.push_back(mk(I_NORI, 1'b1, 1'b0, F_GO,    4'd2));
        vecs.push_back(mk(I_NORI, 1'b1, 1'b0, DEC,     4'd2));
        vecs.push_back(mk(I_NORI, 1'b1, 1'b0, NORI_E,  4'd2));
        vecs.push_back(mk(I_NORI, 1'b1, 1'b0, WB_REG,  4'd2));
        vecs.push_back(mk(I_ANDR, 1'b1, 1'b0, F_GO,    4'd3));
        vecs.push_back(mk(I_ANDR, 1'b1, 1'b0, DEC,     4'd3));
        vecs.push_back(mk(I_ANDR, 1'b1, 1'b0, ANDR_E,  4'd3));
        vecs.push_back(mk(I_ANDR, 1'b1, 1'b0, WB_REG,  4'd3));
        vecs.push_back(mk(I_JR,   1'b1, 1'b0, F_GO,    4'd4));
        vecs.push_back(mk(I_JR,   1'b1, 1'b0, DEC,     4'd4));
        vecs.push_back(mk(I_JR,   1'b1, 1'b0, JR_E,    4'd4));
        vecs.push_back(mk(I_JAL,  1'b1, 1'b0, F_GO,    4'd5));
        vecs.push_back(mk(I_JAL,  1'b1, 1'b0, DEC,     4'd5));
        vecs.push_back(mk(I_JAL,  1'b1, 1'b0, JAL_E,   4'd5));
        vecs.push_back(mk(I_JAL,  1'b1, 1'b0, JAL_W,   4'd5));
        vecs.push_back(mk(I_BLEU, 1'b1, 1'b1, F_GO,    4'd6));
        vecs.push_back(mk(I_BLEU, 1'b1, 1'b1, DEC,     4'd6));
        vecs.push_back(mk(I_BLEU, 1'b1, 1'b1, BLEU1_E, 4'd6));
        vecs.push_back(mk(I_BLEU, 1'b1, 1'b0, F_GO,    4'd7));
        vecs.push_back(mk(I_BLEU, 1'b1, 1'b0, DEC,     4'd7));
        vecs.push_back(mk(I_BLEU, 1'b1, 1'b0, BLEU0_E, 4'd7));
        vecs.push_back(mk(I_NOTR, 1'b1, 1'b0, F_GO,    4'd8));
        vecs.push_back(mk(I_NOTR, 1'b1, 1'b0, DEC,     4'd8));
        vecs.push_back(mk(I_NOTR, 1'b1, 1'b0, NOTR_E,  4'd8));
        vecs.push_back(mk(I_NOTR, 1'b1, 1'b0, WB_REG,  4'd8));
        vecs.push_back(mk(I_NORR, 1'b1, 1'b0, F_GO,    4'd9));
        vecs.push_back(mk(I_NORR, 1'b1, 1'b0, DEC,     4'd9));
        vecs.push_back(mk(I_NORR, 1'b1, 1'b0, NORR_E,  4'd9));
        vecs.push_back(mk(I_NORR, 1'b1, 1'b0, WB_REG,  4'd9));
        vecs.push_back(mk(I_JR,   1'b1, 1'b0, F_GO,    4'd10));

        // Reset state: strobes low even with mem_ready high.
        reset_n = 1'b0; mem_ready = 1'b1; branch_cond = 1'b0; ins = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 32'(act_o), 32'(RST_O));
        chk("reset retired", 32'(retired), 32'd0);
        chk("reset traps", 32'({illegal, bus_err}), 32'd0);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            ins = vecs[i].ins; mem_ready = vecs[i].rdy; branch_cond = vecs[i].bc;
            #1;
            chk($sformatf("vec%0d outputs", i), 32'(act_o), 32'(vecs[i].exp_o));
            chk($sformatf("vec%0d retired", i), 32'(retired), 32'(vecs[i].exp_ret));
            tick();
        end

        // Asynchronous abort in MEM: mem_req must drop without a clock edge.
        ins = I_LW; mem_ready = 1'b1;
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("abort pre state", 32'(state), 32'd3);
        chk("abort pre mem_req", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort mem_req", 32'(mem_req), 32'd0);
        chk("abort state", 32'(state), 32'd0);
        chk("abort retired", 32'(retired), 32'd0);

        // Illegal opcode traps after DECODE and holds until reset.
        do_reset();
        ins = I_ILL; mem_ready = 1'b1;
        tick();
        chk("ill decode state", 32'(state), 32'd1);
        chk("ill decode flag", 32'(illegal), 32'd0);
        tick();
        chk("ill trap outputs", 32'(act_o), 32'(TRAP_O));
        chk("ill flag", 32'(illegal), 32'd1);
        repeat (3) tick();
        chk("ill held", 32'({state, illegal, mem_req}), 32'({3'd5, 1'b1, 1'b0}));
        reset_n = 1'b0;
        #1;
        chk("ill cleared", 32'(illegal), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("ill mem_req back", 32'(mem_req), 32'd1);

        // Rotate opcode depends on the build option.
        do_reset();
        ins = I_ROLV; mem_ready = 1'b1;
        tick();
        tick();
`ifdef MC_CTRL_ROT_EN
        chk("rolv exec", 32'(act_o), 32'(ROLV_E));
        tick();
        chk("rolv wb", 32'(act_o), 32'(WB_REG));
        tick();
        chk("rolv retired", 32'(retired), 32'd1);
`else
        chk("rolv trap", 32'(act_o), 32'(TRAP_O));
        chk("rolv illegal", 32'(illegal), 32'd1);
`endif

        // FETCH timeout: 254 waits still fetching, the 255th traps.
        do_reset();
        repeat (254) tick();
        chk("tmo 254 state", 32'({state, bus_err, mem_req}), 32'({3'd0, 1'b0, 1'b1}));
        tick();
        chk("tmo 255 state", 32'(state), 32'd5);
        chk("tmo bus_err", 32'(bus_err), 32'd1);
        chk("tmo mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b1;
        repeat (4) tick();
        chk("tmo held", 32'({state, bus_err}), 32'({3'd5, 1'b1}));

        // mem_ready on the timeout cycle wins.
        do_reset();
        repeat (254) tick();
        mem_ready = 1'b1;
        tick();
        chk("tmo race state", 32'(state), 32'd1);
        chk("tmo race bus_err", 32'(bus_err), 32'd0);

        // Back-to-back jr, 3 cycles each: retired wraps 15 -> 0.
        do_reset();
        ins = I_JR; mem_ready = 1'b1;
        repeat (45) tick();
        chk("wrap 15", 32'({state, retired}), 32'({3'd0, 4'd15}));
        repeat (3) tick();
        chk("wrap 0", 32'({state, retired}), 32'({3'd0, 4'd0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
